// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline registers.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   // Default payload widths for the EX/MA and MA/WB stage instantiations.
   localparam int unsigned EXMA_CTRL_W = 16;
   localparam int unsigned EXMA_DATA_W = 128;
   localparam int unsigned MAWB_CTRL_W = 8;
   localparam int unsigned MAWB_DATA_W = 96;

   localparam int unsigned PERF_CNT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for stage performance statistics.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count qualifying cycles, stick at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (inc && (count != {W{1'b1}}))
         count <= count + W'(1);
   end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready register with optional skid entry,
// flush, bubble control zeroing and stall/bubble performance counters.
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int unsigned CTRL_W     = EXMA_CTRL_W,
   parameter int unsigned DATA_W     = EXMA_DATA_W,
   parameter int unsigned SKID       = 1,
   parameter int unsigned CLEAR_DATA = 0,
   parameter int unsigned CNT_W      = PERF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam bit USE_SKID = (SKID != 0);
   localparam bit CLR_DATA = (CLEAR_DATA != 0);

   state_t            state_q, state_d;
   logic              in_ready_q;
   logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_d, ctrl_d;
   logic [DATA_W-1:0] skid_data, skid_data_d, data_d;
   logic              accept, emit;

   // Without a skid entry the upstream sees downstream ready directly.
   assign in_ready = USE_SKID ? in_ready_q : (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign emit     = out_valid && out_ready;

   // State and payload registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
         out_valid  <= 1'b0;
         out_ctrl   <= '0;
         out_data   <= '0;
         skid_ctrl  <= '0;
         skid_data  <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != ST_FULL);
         out_valid  <= (state_d != ST_EMPTY);
         out_ctrl   <= ctrl_d;
         out_data   <= data_d;
         skid_ctrl  <= skid_ctrl_d;
         skid_data  <= skid_data_d;
      end
   end

   // Next state and payload; flush overrides every transfer.
   always_comb begin
      state_d     = state_q;
      ctrl_d      = out_ctrl;
      data_d      = out_data;
      skid_ctrl_d = skid_ctrl;
      skid_data_d = skid_data;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d = ST_BUSY;
               ctrl_d  = in_ctrl;
               data_d  = in_data;
            end
         end
         ST_BUSY: begin
            if (accept && emit) begin
               ctrl_d = in_ctrl;
               data_d = in_data;
            end else if (accept) begin
               // Only reachable with a skid entry: ready was registered high.
               state_d     = ST_FULL;
               skid_ctrl_d = in_ctrl;
               skid_data_d = in_data;
            end else if (emit) begin
               state_d = ST_EMPTY;
               ctrl_d  = '0;
               if (CLR_DATA) data_d = '0;
            end
         end
         ST_FULL: begin
            if (emit) begin
               state_d = ST_BUSY;
               ctrl_d  = skid_ctrl;
               data_d  = skid_data;
            end
         end
         default: begin
            state_d = ST_EMPTY;
            ctrl_d  = '0;
         end
      endcase
      if (flush) begin
         state_d = ST_EMPTY;
         ctrl_d  = '0;
         if (CLR_DATA) begin
            data_d      = '0;
            skid_data_d = '0;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (out_valid && !out_ready),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (!out_valid),
      .count (bubble_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: four builds share one stimulus.
module tb_pipe_stage_elastic;

   logic       clk = 1'b0;
   logic       reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [3:0] in_ctrl = '0;
   logic [7:0] in_data = '0;

   int n_cmp = 0;
   int n_err = 0;

   // a: skid, hold data   b: skid, clear data   c: no skid   d: skid, 4-bit counters
   logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
   logic        c_in_ready, c_out_valid, d_in_ready, d_out_valid;
   logic [3:0]  a_out_ctrl, b_out_ctrl, c_out_ctrl, d_out_ctrl;
   logic [7:0]  a_out_data, b_out_data, c_out_data, d_out_data;
   logic [15:0] a_stall, a_bubble, b_stall, b_bubble, c_stall, c_bubble;
   logic [3:0]  d_stall, d_bubble;

   always #5 clk = ~clk;

   pipe_stage_elastic #(.CTRL_W(4), .DATA_W(8), .SKID(1), .CLEAR_DATA(0), .CNT_W(16)) u_a (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_ctrl(a_out_ctrl), .out_data(a_out_data), .stall_cnt(a_stall), .bubble_cnt(a_bubble));

   pipe_stage_elastic #(.CTRL_W(4), .DATA_W(8), .SKID(1), .CLEAR_DATA(1), .CNT_W(16)) u_b (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_ctrl(b_out_ctrl), .out_data(b_out_data), .stall_cnt(b_stall), .bubble_cnt(b_bubble));

   pipe_stage_elastic #(.CTRL_W(4), .DATA_W(8), .SKID(0), .CLEAR_DATA(0), .CNT_W(16)) u_c (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
      .out_ctrl(c_out_ctrl), .out_data(c_out_data), .stall_cnt(c_stall), .bubble_cnt(c_bubble));

   pipe_stage_elastic #(.CTRL_W(4), .DATA_W(8), .SKID(1), .CLEAR_DATA(0), .CNT_W(4)) u_d (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(d_out_valid), .out_ready(out_ready),
      .out_ctrl(d_out_ctrl), .out_data(d_out_data), .stall_cnt(d_stall), .bubble_cnt(d_bubble));

   // Row = inputs held for one cycle, plus outputs expected in that same cycle
   // (registered values from the previous edge, in_ready for the current cycle).
   typedef struct {
      logic        rst, fl, iv;
      logic [3:0]  ictrl;
      logic [7:0]  idata;
      logic        ordy, chk, ov, ir;
      logic [3:0]  octrl;
      logic [7:0]  odata, bdata;
      logic [15:0] stall, bubble;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];

   function automatic vec_t mk(logic rst, logic fl, logic iv, logic [3:0] ic, logic [7:0] id,
                               logic ordy, logic chk, logic ov, logic ir, logic [3:0] oc,
                               logic [7:0] od, logic [7:0] bd, logic [15:0] st, logic [15:0] bu);
      vec_t v;
      v.rst = rst; v.fl = fl; v.iv = iv; v.ictrl = ic; v.idata = id; v.ordy = ordy;
      v.chk = chk; v.ov = ov; v.ir = ir; v.octrl = oc; v.odata = od; v.bdata = bd;
      v.stall = st; v.bubble = bu;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic rst, input logic fl, input logic iv, input logic [3:0] ic,
                       input logic [7:0] id, input logic ordy);
      @(posedge clk);
      #1;
      reset = rst; flush = fl; in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy;
      #1;
   endtask

   initial begin
      //              rst fl iv ictrl idata  ordy chk ov ir octrl odata  bdata  stall bubble
      vecs[0]  = mk(1, 0, 0, 4'h0, 8'h00, 0, 0, 0, 0, 4'h0, 8'h00, 8'h00, 0, 0);
      vecs[1]  = mk(0, 0, 0, 4'h0, 8'h00, 0, 1, 0, 1, 4'h0, 8'h00, 8'h00, 0, 0);
      // streaming 1,2,3
      vecs[2]  = mk(0, 0, 1, 4'h1, 8'h01, 1, 1, 0, 1, 4'h0, 8'h00, 8'h00, 0, 1);
      vecs[3]  = mk(0, 0, 1, 4'h2, 8'h02, 1, 1, 1, 1, 4'h1, 8'h01, 8'h01, 0, 2);
      vecs[4]  = mk(0, 0, 1, 4'h3, 8'h03, 1, 1, 1, 1, 4'h2, 8'h02, 8'h02, 0, 2);
      vecs[5]  = mk(0, 0, 0, 4'h0, 8'h00, 1, 1, 1, 1, 4'h3, 8'h03, 8'h03, 0, 2);
      // two bubble cycles: ctrl zero, data held (a) / zeroed (b)
      vecs[6]  = mk(0, 0, 0, 4'h0, 8'h00, 1, 1, 0, 1, 4'h0, 8'h03, 8'h00, 0, 2);
      vecs[7]  = mk(0, 0, 0, 4'h0, 8'h00, 1, 1, 0, 1, 4'h0, 8'h03, 8'h00, 0, 3);
      // backpressure: A then B with out_ready low for three valid cycles
      vecs[8]  = mk(0, 0, 1, 4'hA, 8'h0A, 0, 1, 0, 1, 4'h0, 8'h03, 8'h00, 0, 4);
      vecs[9]  = mk(0, 0, 1, 4'hB, 8'h0B, 0, 1, 1, 1, 4'hA, 8'h0A, 8'h0A, 0, 5);
      vecs[10] = mk(0, 0, 0, 4'h0, 8'h00, 0, 1, 1, 0, 4'hA, 8'h0A, 8'h0A, 1, 5);
      vecs[11] = mk(0, 0, 0, 4'h0, 8'h00, 0, 1, 1, 0, 4'hA, 8'h0A, 8'h0A, 2, 5);
      vecs[12] = mk(0, 0, 0, 4'h0, 8'h00, 1, 1, 1, 0, 4'hA, 8'h0A, 8'h0A, 3, 5);
      vecs[13] = mk(0, 0, 0, 4'h0, 8'h00, 1, 1, 1, 1, 4'hB, 8'h0B, 8'h0B, 3, 5);
      vecs[14] = mk(0, 0, 0, 4'h0, 8'h00, 1, 1, 0, 1, 4'h0, 8'h0B, 8'h00, 3, 5);
      // fill to FULL, then flush with 0xC offered
      vecs[15] = mk(0, 0, 1, 4'h1, 8'h11, 0, 1, 0, 1, 4'h0, 8'h0B, 8'h00, 3, 6);
      vecs[16] = mk(0, 0, 1, 4'h2, 8'h12, 0, 1, 1, 1, 4'h1, 8'h11, 8'h11, 3, 7);
      vecs[17] = mk(0, 1, 1, 4'hC, 8'h0C, 0, 1, 1, 0, 4'h1, 8'h11, 8'h11, 4, 7);
      vecs[18] = mk(0, 0, 0, 4'h0, 8'h00, 1, 1, 0, 1, 4'h0, 8'h11, 8'h00, 5, 7);
      vecs[19] = mk(0, 0, 0, 4'h0, 8'h00, 1, 1, 0, 1, 4'h0, 8'h11, 8'h00, 5, 8);
      // reset together with flush and a valid input
      vecs[20] = mk(1, 1, 1, 4'h3, 8'h33, 0, 1, 0, 1, 4'h0, 8'h11, 8'h00, 5, 9);
      vecs[21] = mk(0, 0, 0, 4'h0, 8'h00, 0, 1, 0, 1, 4'h0, 8'h00, 8'h00, 0, 0);

      for (int i = 0; i < NV; i++) begin
         step(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].ictrl, vecs[i].idata, vecs[i].ordy);
         if (vecs[i].chk) begin
            check($sformatf("row%0d a_out_valid", i), 32'(a_out_valid), 32'(vecs[i].ov));
            check($sformatf("row%0d a_in_ready", i),  32'(a_in_ready),  32'(vecs[i].ir));
            check($sformatf("row%0d a_out_ctrl", i),  32'(a_out_ctrl),  32'(vecs[i].octrl));
            check($sformatf("row%0d a_out_data", i),  32'(a_out_data),  32'(vecs[i].odata));
            check($sformatf("row%0d a_stall", i),     32'(a_stall),     32'(vecs[i].stall));
            check($sformatf("row%0d a_bubble", i),    32'(a_bubble),    32'(vecs[i].bubble));
            check($sformatf("row%0d b_out_valid", i), 32'(b_out_valid), 32'(vecs[i].ov));
            check($sformatf("row%0d b_out_ctrl", i),  32'(b_out_ctrl),  32'(vecs[i].octrl));
            check($sformatf("row%0d b_out_data", i),  32'(b_out_data),  32'(vecs[i].bdata));
         end
      end

      // No-skid build: combinational ready, full-throughput emit+accept.
      step(0, 0, 1, 4'h1, 8'h21, 0);
      check("ns idle in_ready", 32'(c_in_ready), 32'd1);
      step(0, 0, 1, 4'h2, 8'h22, 0);
      check("ns held valid", 32'(c_out_valid), 32'd1);
      check("ns held data", 32'(c_out_data), 32'h21);
      check("ns held ctrl", 32'(c_out_ctrl), 32'h1);
      check("ns stalled in_ready", 32'(c_in_ready), 32'd0);
      step(0, 0, 1, 4'h2, 8'h22, 1);
      check("ns release in_ready", 32'(c_in_ready), 32'd1);
      check("ns release data", 32'(c_out_data), 32'h21);
      step(0, 0, 1, 4'h3, 8'h23, 1);
      check("ns stream data 22", 32'(c_out_data), 32'h22);
      check("ns stream in_ready", 32'(c_in_ready), 32'd1);
      check("skid stream data 22", 32'(a_out_data), 32'h22);
      step(0, 0, 0, 4'h0, 8'h00, 1);
      check("ns stream data 23", 32'(c_out_data), 32'h23);
      check("ns stream valid 23", 32'(c_out_valid), 32'd1);
      check("skid stream data 23", 32'(a_out_data), 32'h23);
      step(0, 0, 0, 4'h0, 8'h00, 1);
      check("ns drained valid", 32'(c_out_valid), 32'd0);
      check("ns drained ctrl", 32'(c_out_ctrl), 32'h0);
      check("ns drained data", 32'(c_out_data), 32'h23);

      // 4-bit counters: long stall saturates at 15, reset clears.
      step(1, 0, 0, 4'h0, 8'h00, 0);
      step(0, 0, 1, 4'h5, 8'h55, 0);
      check("sat start stall", 32'(d_stall), 32'd0);
      check("sat start bubble", 32'(d_bubble), 32'd0);
      repeat (15) step(0, 0, 0, 4'h0, 8'h00, 0);
      check("sat stall 14", 32'(d_stall), 32'd14);
      repeat (5) step(0, 0, 0, 4'h0, 8'h00, 0);
      check("sat stall 15", 32'(d_stall), 32'd15);
      check("sat bubble", 32'(d_bubble), 32'd1);
      check("sat hold valid", 32'(d_out_valid), 32'd1);
      check("sat hold data", 32'(d_out_data), 32'h55);
      check("sat hold ctrl", 32'(d_out_ctrl), 32'h5);
      step(1, 0, 0, 4'h0, 8'h00, 0);
      check("sat pre-reset stall", 32'(d_stall), 32'd15);
      step(0, 0, 0, 4'h0, 8'h00, 0);
      check("sat reset stall", 32'(d_stall), 32'd0);
      check("sat reset bubble", 32'(d_bubble), 32'd0);
      check("sat reset valid", 32'(d_out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (ID/EX, EX/MA, MA/WB).
- Carries one generic payload split into a control field and a data field, and moves it with a valid/ready handshake instead of a global enable.
- An optional skid entry lets the upstream stall be registered, so it does not combinationally chain through the pipeline.
- Adds flush, bubble control-zeroing and saturating stall/bubble performance counters.

Parameters:
- CTRL_W, 16: control field width (RegWrite, MemWrite, Mem2Reg, load/store type, mdOp, ...); forced to zero whenever the stage holds a bubble.
- DATA_W, 128: data field width (Instr, ALU result, forwarded rt value, pc+4, A3, ...).
- SKID, 1: 0 = single register, combinational in_ready; 1 = main register plus one skid entry, registered in_ready.
- CLEAR_DATA, 0: 1 = data field is also zeroed on reset, flush and bubble; 0 = data field is held.
- CNT_W, 16: width of each performance counter.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- flush, in, 1: synchronous kill of all held entries (branch/exception redirect).
- in_valid, in, 1: upstream offers a payload.
- in_ready, out, 1: stage can accept a payload this cycle.
- in_ctrl, in, CTRL_W: upstream control field.
- in_data, in, DATA_W: upstream data field.
- out_valid, out, 1: downstream payload is valid.
- out_ready, in, 1: downstream accepts the payload this cycle.
- out_ctrl, out, CTRL_W: downstream control field; all zero when out_valid=0.
- out_data, out, DATA_W: downstream data field.
- stall_cnt, out, CNT_W: cycles with out_valid && !out_ready.
- bubble_cnt, out, CNT_W: cycles with !out_valid.

Behaviour:
- Reset:
  - out_valid=0, out_ctrl=0, out_data=0, skid empty.
  - in_ready=1 for SKID=1; for SKID=0 in_ready follows its equation and is 1 after reset.
  - stall_cnt=0, bubble_cnt=0.
  - Reset overrides every other input.
- Transfers:
  - Accept occurs when in_valid && in_ready at a rising edge.
  - Emit occurs when out_valid && out_ready.
  - Latency is 1 cycle: a payload accepted at edge N appears on out_* after edge N.
  - Payload order is strictly FIFO.
  - No payload is duplicated or dropped unless flushed.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - On accept, the main register loads; otherwise, if emitting, out_valid clears.
- SKID=1 state machine:
  - EMPTY: out_valid=0, in_ready=1.
    - Accept -> BUSY.
  - BUSY: main full, skid empty, in_ready=1.
    - Accept && emit -> BUSY (main loads new payload).
    - Accept && !emit -> FULL (payload goes to skid).
    - !Accept && emit -> EMPTY.
    - Otherwise stay.
  - FULL: main and skid full, in_ready=0 (registered).
    - Emit -> BUSY (skid moves to main).
    - Otherwise stay.
  - in_ready is a flop output equal to (next_state != FULL).
- Flush:
  - Next state is EMPTY; out_valid=0; out_ctrl=0 next cycle.
  - The skid entry is discarded.
  - A payload accepted in the same cycle is discarded.
  - Flush takes priority over accept, emit and stall.
  - Data field is zeroed only if CLEAR_DATA=1.
- Bubble:
  - Whenever out_valid is 0, out_ctrl is 0.
  - This guarantees a bubble produces no register or memory writes downstream.
- Hold:
  - When out_valid && !out_ready, out_ctrl and out_data are stable until emit or flush.
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at 2^CNT_W-1 (no wrap).
  - Cycles where flush or reset is asserted still count, based on the current out_valid.
  - Counters clear only on reset.
- Simultaneous reset and flush: reset behaviour applies.

Decomposition:
- Shared package pipe_pkg holds:
  - State encoding: ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2.
  - Default widths for the EX/MA and MA/WB instantiations, e.g. EXMA_CTRL_W and EXMA_DATA_W.
- One natural sub-module, sat_counter (parameter W; inputs clk, reset, inc; output count), instantiated twice.

Test Plan:
- Streaming: reset, then in_valid=1 and out_ready=1 constantly with in_data=1,2,3,... -> out_data=1,2,3 on consecutive cycles, one cycle behind the input; stall_cnt=0; in_ready=1 throughout.
- Backpressure, SKID=1:
  - Present A=0xA, B=0xB while out_ready=0 for 3 cycles -> state FULL; in_ready=0 from the cycle after B is accepted.
  - out_valid=1 and out_data=0xA are held all 3 cycles; stall_cnt=3.
  - Then out_ready=1 -> 0xA, then 0xB are emitted; no loss.
- Flush while FULL:
  - Assert flush with in_valid=1, in_data=0xC -> next cycle out_valid=0, out_ctrl=0, in_ready=1.
  - 0xC is never emitted; with CLEAR_DATA=1, out_data=0.
- Bubble:
  - in_valid=0 for 2 cycles after the last emit -> out_ctrl=0, bubble_cnt increments by exactly 2.
  - With CLEAR_DATA=0, out_data retains the last value.
- SKID=0 build:
  - out_ready=0 -> in_ready=0 in the same cycle.
  - out_ready=1 with out_valid=1 and in_valid=1 -> simultaneous emit and accept each cycle, full throughput.
- Saturation, CNT_W=4: hold a stall for 20 cycles -> stall_cnt stops at 15; reset clears both counters to 0 on the next edge.
